spi_master: RTL

//  SPI controller: the initiator end of the link served by our SPI peripheral. Runs on sysclk, drives SCLK/MOSI/CS, samples MISO.

---
 rtl/spi_master.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 initiator with byte valid/ready host side and CS bursting
//
// Drives SCLK/MOSI/CS toward a peripheral and samples MISO, all on sysclk.
// Bytes go out MSB first. A byte offered in the burst window (last cycle of
// the 8th SCLK-high phase) follows with no CS gap and no setup time.
//
// Optional build: define SPI_MASTER_LOOPBACK_EN to add the iLoopback input.
// When iLoopback=1, MISO is taken from the registered MOSI pin value.
//
// Ports:
//   sysclk    in   system clock, everything on posedge
//   reset     in   synchronous active-high reset
//   iTxValid  in   host offers iTx
//   iTx       in   byte to transmit
//   oTxReady  out  iTx taken on this cycle when iTxValid is also high
//   oRxValid  out  one-cycle strobe, oRx holds a new byte
//   oRx       out  last received byte
//   oBusy     out  transfer machinery not idle
//   oSPIClk   out  SCLK, idles low
//   oSPIMOSI  out  MOSI
//   iSPIMISO  in   MISO, already synchronous to sysclk
//   iLoopback in   (SPI_MASTER_LOOPBACK_EN only) sample MOSI instead of MISO
//   oSPICS    out  chip select, active low
module spi_master #(
    parameter int CLK_DIV        = 4,
    parameter int CS_SETUP       = 2,
    parameter int CS_HOLD        = 2,
    parameter int MISO_LSB_FIRST = 1
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       iTxValid,
    input  logic [7:0] iTx,
    output logic       oTxReady,
    output logic       oRxValid,
    output logic [7:0] oRx,
    output logic       oBusy,
    output logic       oSPIClk,
    output logic       oSPIMOSI,
    input  logic       iSPIMISO,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic       iLoopback,
`endif
    output logic       oSPICS
);

    // One shared phase counter serves every timed state, so it must hold
    // the largest of the three phase lengths.
    localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int CNT_MAX = (MAX_A > CS_HOLD) ? MAX_A : CS_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } stateT;

    stateT            state, stateNext;
    logic [CNT_W-1:0] phaseCnt, phaseCntNext;
    logic [2:0]       bitCnt, bitCntNext;
    // MOSI pin itself holds the current bit; txShift holds the bits still to go.
    logic [6:0]       txShift, txShiftNext;
    // Seven bits of history; the eighth arrives on the completing edge.
    logic [6:0]       rxShift, rxShiftNext;
    logic [7:0]       rxNext;
    logic             rxValidNext;
    logic             txReadyNext;
    logic             csNext;
    logic             sclkNext;
    logic             mosiNext;

    logic             phaseLast;
    logic             accept;
    logic             misoBit;
    logic [7:0]       rxByte;

    assign accept = iTxValid & oTxReady;
    assign oBusy  = (state != IDLE);

`ifdef SPI_MASTER_LOOPBACK_EN
    assign misoBit = iLoopback ? oSPIMOSI : iSPIMISO;
`else
    assign misoBit = iSPIMISO;
`endif

    // Byte as it stands once the current MISO sample is folded in.
    assign rxByte = (MISO_LSB_FIRST != 0) ? {misoBit, rxShift}
                                          : {rxShift, misoBit};

    always_comb begin
        phaseLast = 1'b0;
        case (state)
            SETUP:     phaseLast = (phaseCnt == SETUP_LAST);
            LOW, HIGH: phaseLast = (phaseCnt == DIV_LAST);
            HOLD, GAP: phaseLast = (phaseCnt == HOLD_LAST);
            default:   phaseLast = 1'b0;
        endcase
    end

    always_comb begin
        stateNext    = state;
        phaseCntNext = phaseCnt + CNT_W'(1);
        bitCntNext   = bitCnt;
        txShiftNext  = txShift;
        rxShiftNext  = rxShift;
        rxNext       = oRx;
        rxValidNext  = 1'b0;
        csNext       = oSPICS;
        sclkNext     = oSPIClk;
        mosiNext     = oSPIMOSI;

        case (state)
            IDLE: begin
                phaseCntNext = '0;
                csNext       = 1'b1;
                sclkNext     = 1'b0;
                if (accept) begin
                    stateNext   = SETUP;
                    txShiftNext = iTx[6:0];
                    mosiNext    = iTx[7];
                    csNext      = 1'b0;
                    bitCntNext  = 3'd0;
                end
            end
            SETUP: begin
                if (phaseLast) begin
                    stateNext    = LOW;
                    phaseCntNext = '0;
                end
            end
            LOW: begin
                if (phaseLast) begin
                    stateNext    = HIGH;
                    phaseCntNext = '0;
                    sclkNext     = 1'b1;
                end
            end
            HIGH: begin
                if (phaseLast) begin
                    // Falling edge: sample MISO, advance MOSI, count the bit.
                    sclkNext     = 1'b0;
                    phaseCntNext = '0;
                    rxShiftNext  = (MISO_LSB_FIRST != 0) ? rxByte[7:1] : rxByte[6:0];
                    bitCntNext   = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        rxNext      = rxByte;
                        rxValidNext = 1'b1;
                        if (accept) begin
                            // Burst: next MSB goes out on this same falling edge.
                            stateNext   = LOW;
                            txShiftNext = iTx[6:0];
                            mosiNext    = iTx[7];
                        end else begin
                            stateNext = HOLD;
                            mosiNext  = 1'b0;
                        end
                    end else begin
                        stateNext   = LOW;
                        txShiftNext = {txShift[5:0], 1'b0};
                        mosiNext    = txShift[6];
                    end
                end
            end
            HOLD: begin
                if (phaseLast) begin
                    stateNext    = GAP;
                    phaseCntNext = '0;
                    csNext       = 1'b1;
                end
            end
            GAP: begin
                if (phaseLast) begin
                    stateNext    = IDLE;
                    phaseCntNext = '0;
                end
            end
            default: begin
                stateNext    = IDLE;
                phaseCntNext = '0;
                csNext       = 1'b1;
                sclkNext     = 1'b0;
                mosiNext     = 1'b0;
            end
        endcase

        // Ready is registered: raise it for the cycle the machine is about to
        // spend in IDLE, or for the final cycle of the eighth high phase.
        txReadyNext = (stateNext == IDLE) ||
                      ((stateNext == HIGH) && (bitCntNext == 3'd7) &&
                       (phaseCntNext == DIV_LAST));
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= IDLE;
            phaseCnt <= '0;
            bitCnt   <= 3'd0;
            txShift  <= '0;
            rxShift  <= '0;
            oRx      <= 8'h00;
            oRxValid <= 1'b0;
            oTxReady <= 1'b0;
            oSPICS   <= 1'b1;
            oSPIClk  <= 1'b0;
            oSPIMOSI <= 1'b0;
        end else begin
            state    <= stateNext;
            phaseCnt <= phaseCntNext;
            bitCnt   <= bitCntNext;
            txShift  <= txShiftNext;
            rxShift  <= rxShiftNext;
            oRx      <= rxNext;
            oRxValid <= rxValidNext;
            oTxReady <= txReadyNext;
            oSPICS   <= csNext;
            oSPIClk  <= sclkNext;
            oSPIMOSI <= mosiNext;
        end
    end

endmodule
